// File: rtl/alu_pkg.sv
// Shared ALU encodings plus the issue-stage state and held-entry types.
// The ALU and the issue stage both import this package.
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_MUL  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1001;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_NAND = 4'b1101;

    localparam logic [2:0] BONUS_SLT = 3'b000;
    localparam logic [2:0] BONUS_SGT = 3'b001;
    localparam logic [2:0] BONUS_SLE = 3'b010;
    localparam logic [2:0] BONUS_SGE = 3'b011;
    localparam logic [2:0] BONUS_SNE = 3'b100;
    localparam logic [2:0] BONUS_SEQ = 3'b110;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } issue_state_t;

    typedef struct packed {
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic        alu_src_imm;
        logic        reg_write;
        logic        mem_read;
        logic [3:0]  alu_control;
        logic [2:0]  bonus_control;
    } entry_t;

endpackage

// File: rtl/fwd_mux.sv
// Operand bypass: picks the EX/MEM bus, then the MEM/WB bus, then the
// register-file value. Register 0 is hard-wired and never bypassed.
module fwd_mux (
    input  logic [4:0]  r,
    input  logic [31:0] d,
    input  logic        fwd1_we,
    input  logic [4:0]  fwd1_rd,
    input  logic [31:0] fwd1_data,
    input  logic        fwd2_we,
    input  logic [4:0]  fwd2_rd,
    input  logic [31:0] fwd2_data,
    output logic [31:0] q
);

    always_comb begin
        q = d;
        if (r != 5'd0 && fwd1_we && fwd1_rd == r) begin
            q = fwd1_data;
        end else if (r != 5'd0 && fwd2_we && fwd2_rd == r) begin
            q = fwd2_data;
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// One-entry issue buffer between decode and the ALU: holds an op, bypasses
// its operands from the result buses and stalls a consumer of a pending load.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_rs,
    input  logic [4:0]       in_rt,
    input  logic [4:0]       in_rd,
    input  logic [31:0]      in_rs_data,
    input  logic [31:0]      in_rt_data,
    input  logic [31:0]      in_imm,
    input  logic             in_alu_src_imm,
    input  logic             in_uses_rt,
    input  logic             in_reg_write,
    input  logic             in_mem_read,
    input  logic [3:0]       in_alu_control,
    input  logic [2:0]       in_bonus_control,
    input  logic             fwd1_we,
    input  logic [4:0]       fwd1_rd,
    input  logic [31:0]      fwd1_data,
    input  logic             fwd2_we,
    input  logic [4:0]       fwd2_rd,
    input  logic [31:0]      fwd2_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      src1,
    output logic [31:0]      src2,
    output logic [3:0]       alu_control,
    output logic [2:0]       bonus_control,
    output logic [4:0]       out_rd,
    output logic             out_reg_write,
    output logic             out_mem_read,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             state_dbg
);

    // Handshake: a transfer happens on the rising edge where valid and ready
    // are both high; valid never depends on ready, and an offered entry is
    // held stable until it transfers (or is flushed / reset away).
    issue_state_t state;
    entry_t       held;
    logic         live;
    logic         hazard;
    logic         in_fire;
    logic         out_fire;
    logic [31:0]  fwd_rs;
    logic [31:0]  fwd_rt;

    // Gating with rst_n keeps a reset cycle from ever reporting a transfer.
    assign live      = rst_n && (state == ST_FULL);
    assign state_dbg = (state == ST_FULL);

    assign hazard = live && held.mem_read && held.reg_write && (held.rd != 5'd0) &&
                    ((in_rs == held.rd) || (in_uses_rt && (in_rt == held.rd)));

    assign in_ready = rst_n && !flush && !hazard && (!live || out_ready);
    assign in_fire  = in_valid && in_ready;
    assign out_fire = live && out_ready;

    fwd_mux u_fwd_rs (
        .r(held.rs), .d(held.rs_data),
        .fwd1_we(fwd1_we), .fwd1_rd(fwd1_rd), .fwd1_data(fwd1_data),
        .fwd2_we(fwd2_we), .fwd2_rd(fwd2_rd), .fwd2_data(fwd2_data),
        .q(fwd_rs)
    );

    fwd_mux u_fwd_rt (
        .r(held.rt), .d(held.rt_data),
        .fwd1_we(fwd1_we), .fwd1_rd(fwd1_rd), .fwd1_data(fwd1_data),
        .fwd2_we(fwd2_we), .fwd2_rd(fwd2_rd), .fwd2_data(fwd2_data),
        .q(fwd_rt)
    );

    assign out_valid     = live;
    assign src1          = live ? fwd_rs : 32'd0;
    assign src2          = live ? (held.alu_src_imm ? held.imm : fwd_rt) : 32'd0;
    assign alu_control   = live ? held.alu_control : 4'd0;
    assign bonus_control = live ? held.bonus_control : 3'd0;
    assign out_rd        = live ? held.rd : 5'd0;
    assign out_reg_write = live && held.reg_write;
    assign out_mem_read  = live && held.mem_read;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_EMPTY;
            held      <= '0;
            stall_cnt <= '0;
        end else begin
            if (in_valid && hazard && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush) begin
                state <= ST_EMPTY;
            end else if (in_fire) begin
                state              <= ST_FULL;
                held.rs            <= in_rs;
                held.rt            <= in_rt;
                held.rd            <= in_rd;
                held.rs_data       <= in_rs_data;
                held.rt_data       <= in_rt_data;
                held.imm           <= in_imm;
                held.alu_src_imm   <= in_alu_src_imm;
                held.reg_write     <= in_reg_write;
                held.mem_read      <= in_mem_read;
                held.alu_control   <= in_alu_control;
                held.bonus_control <= in_bonus_control;
            end else if (out_fire) begin
                state <= ST_EMPTY;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: a one-entry reference model checked
// every cycle, plus hand-computed literal expectations at key points.
module tb_alu_issue_stage;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       in_rs, in_rt, in_rd;
    logic [31:0]      in_rs_data, in_rt_data, in_imm;
    logic             in_alu_src_imm, in_uses_rt, in_reg_write, in_mem_read;
    logic [3:0]       in_alu_control;
    logic [2:0]       in_bonus_control;
    logic             fwd1_we, fwd2_we;
    logic [4:0]       fwd1_rd, fwd2_rd;
    logic [31:0]      fwd1_data, fwd2_data;
    logic             out_valid, out_ready;
    logic [31:0]      src1, src2;
    logic [3:0]       alu_control;
    logic [2:0]       bonus_control;
    logic [4:0]       out_rd;
    logic             out_reg_write, out_mem_read;
    logic [CNT_W-1:0] stall_cnt;
    logic             state_dbg;

    int checks = 0;
    int errors = 0;

    alu_issue_stage #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_rs_data(in_rs_data), .in_rt_data(in_rt_data), .in_imm(in_imm),
        .in_alu_src_imm(in_alu_src_imm), .in_uses_rt(in_uses_rt),
        .in_reg_write(in_reg_write), .in_mem_read(in_mem_read),
        .in_alu_control(in_alu_control), .in_bonus_control(in_bonus_control),
        .fwd1_we(fwd1_we), .fwd1_rd(fwd1_rd), .fwd1_data(fwd1_data),
        .fwd2_we(fwd2_we), .fwd2_rd(fwd2_rd), .fwd2_data(fwd2_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .src1(src1), .src2(src2),
        .alu_control(alu_control), .bonus_control(bonus_control),
        .out_rd(out_rd), .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
        .stall_cnt(stall_cnt), .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [4:0]  rs, rt, rd;
        logic [31:0] rs_data, rt_data, imm;
        logic        src_imm, reg_write, mem_read;
        logic [3:0]  alu;
        logic [2:0]  bonus;
    } m_entry_t;

    logic       m_full = 1'b0;
    m_entry_t   m_e;
    int         m_cnt = 0;
    logic [8:0] exp_q[$];

    function automatic logic [31:0] m_fwd(input logic [4:0] r, input logic [31:0] d);
        if (r != 0 && fwd1_we && fwd1_rd == r) return fwd1_data;
        if (r != 0 && fwd2_we && fwd2_rd == r) return fwd2_data;
        return d;
    endfunction

    function automatic logic m_hazard();
        if (!(rst_n && m_full)) return 1'b0;
        if (!(m_e.mem_read && m_e.reg_write && m_e.rd != 0)) return 1'b0;
        return (in_rs == m_e.rd) || (in_uses_rt && in_rt == m_e.rd);
    endfunction

    function automatic logic m_in_ready();
        return rst_n && !flush && !m_hazard() && (!m_full || out_ready);
    endfunction

    always @(posedge clk) begin
        logic acc, fire;
        acc  = in_valid && m_in_ready();
        fire = rst_n && m_full && out_ready;
        if (!rst_n) begin
            m_full = 1'b0;
            m_cnt  = 0;
            exp_q.delete();
        end else begin
            if (in_valid && m_hazard() && m_cnt < (1 << CNT_W) - 1) m_cnt++;
            if (flush) begin
                m_full = 1'b0;
                exp_q.delete();
            end else begin
                if (fire && exp_q.size() > 0) void'(exp_q.pop_front());
                if (acc) begin
                    m_full  = 1'b1;
                    m_e.rs = in_rs; m_e.rt = in_rt; m_e.rd = in_rd;
                    m_e.rs_data = in_rs_data; m_e.rt_data = in_rt_data; m_e.imm = in_imm;
                    m_e.src_imm = in_alu_src_imm; m_e.reg_write = in_reg_write;
                    m_e.mem_read = in_mem_read; m_e.alu = in_alu_control;
                    m_e.bonus = in_bonus_control;
                    exp_q.push_back({in_alu_control, in_rd});
                end else if (fire) begin
                    m_full = 1'b0;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic v;
        v = rst_n && m_full;
        check("in_ready", in_ready, m_in_ready());
        check("out_valid", out_valid, v);
        check("src1", src1, v ? m_fwd(m_e.rs, m_e.rs_data) : 32'd0);
        check("src2", src2, v ? (m_e.src_imm ? m_e.imm : m_fwd(m_e.rt, m_e.rt_data)) : 32'd0);
        check("alu_control", alu_control, v ? m_e.alu : 4'd0);
        check("bonus_control", bonus_control, v ? m_e.bonus : 3'd0);
        check("out_rd", out_rd, v ? m_e.rd : 5'd0);
        check("out_reg_write", out_reg_write, v && m_e.reg_write);
        check("out_mem_read", out_mem_read, v && m_e.mem_read);
        check("stall_cnt", stall_cnt, m_cnt);
        check("state_dbg_vs_valid", state_dbg & rst_n, v);
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("sb_unexpected_issue", 1, 0);
            else check("sb_issue", {alu_control, out_rd}, exp_q[0]);
        end
    end

    // ---------------- drivers ----------------
    task automatic set_op(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] imm,
                          input logic src_imm, input logic uses_rt, input logic rw, input logic mr,
                          input logic [3:0] alu, input logic [2:0] bonus);
        in_valid = 1'b1;
        in_rs = rs; in_rt = rt; in_rd = rd;
        in_rs_data = rsd; in_rt_data = rtd; in_imm = imm;
        in_alu_src_imm = src_imm; in_uses_rt = uses_rt;
        in_reg_write = rw; in_mem_read = mr;
        in_alu_control = alu; in_bonus_control = bonus;
    endtask

    task automatic set_fwd(input logic we1, input logic [4:0] rd1, input logic [31:0] d1,
                           input logic we2, input logic [4:0] rd2, input logic [31:0] d2);
        fwd1_we = we1; fwd1_rd = rd1; fwd1_data = d1;
        fwd2_we = we2; fwd2_rd = rd2; fwd2_data = d2;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
        set_op(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 3'd0);
        in_valid = 1'b0;
        set_fwd(0, 0, 0, 0, 0, 0);
        tick(); tick();
        @(negedge clk);
        check("lit_reset_out_valid", out_valid, 0);
        check("lit_reset_in_ready", in_ready, 0);
        check("lit_reset_stall_cnt", stall_cnt, 0);

        // basic ADD: rs=1(5), rt=2(7)
        tick();
        rst_n = 1'b1; out_ready = 1'b1;
        set_op(1, 2, 3, 32'd5, 32'd7, 0, 0, 1, 1, 0, 4'b0010, 3'd0);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("lit_add_valid", out_valid, 1);
        check("lit_add_src1", src1, 32'd5);
        check("lit_add_src2", src2, 32'd7);
        check("lit_add_alu", alu_control, 4'b0010);
        tick();

        // forwarding priority, then MEM/WB only, then register 0 + immediate
        out_ready = 1'b0;
        set_fwd(1, 3, 32'hAA, 1, 3, 32'hBB);
        set_op(3, 0, 7, 32'h11, 32'h22, 0, 0, 1, 1, 0, 4'b0001, 3'b100);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("lit_fwd1_prio", src1, 32'hAA);
        check("lit_rt0_nofwd", src2, 32'h22);
        fwd1_we = 1'b0;
        tick();
        @(negedge clk);
        check("lit_fwd2", src1, 32'hBB);
        tick();
        out_ready = 1'b1;
        set_fwd(1, 0, 32'hAA, 0, 0, 0);
        set_op(0, 3, 8, 32'h33, 32'h44, 32'hFFFF_FFF0, 1, 0, 1, 0, 4'b0111, 3'b110);
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        check("lit_r0_passthru", src1, 32'h33);
        check("lit_imm_sel", src2, 32'hFFFF_FFF0);
        check("lit_bonus", bonus_control, 3'b110);
        out_ready = 1'b1;
        tick();
        set_fwd(0, 0, 0, 0, 0, 0);

        // load-use hazard: load rd=4 then SUB rs=4
        set_op(9, 0, 4, 32'h100, 0, 32'h8, 1, 0, 1, 1, 4'b0010, 3'd0);
        tick();
        set_op(4, 5, 10, 32'h1, 32'h2, 0, 0, 1, 1, 0, 4'b0110, 3'd0);
        @(negedge clk);
        check("lit_hazard_in_ready", in_ready, 0);
        tick();
        @(negedge clk);
        check("lit_bubble_valid", out_valid, 0);
        check("lit_bubble_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("lit_sub_valid", out_valid, 1);
        check("lit_sub_alu", alu_control, 4'b0110);
        check("lit_stall_one", stall_cnt, 1);
        tick();

        // back-pressure: X held while Y waits three cycles, then replaces it
        out_ready = 1'b0;
        set_op(11, 12, 13, 32'h5, 32'h6, 0, 0, 1, 1, 0, 4'b1000, 3'd0);
        tick();
        set_op(14, 15, 16, 32'h7, 32'h8, 0, 0, 1, 1, 0, 4'b1001, 3'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("lit_bp_in_ready", in_ready, 0);
            check("lit_bp_rd", out_rd, 13);
            tick();
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        check("lit_replace_rd", out_rd, 16);

        // flush while FULL with a pending input
        flush = 1'b1;
        set_op(17, 18, 19, 32'h9, 32'hA, 0, 0, 1, 1, 0, 4'b1100, 3'd0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("lit_flush_valid", out_valid, 0);
        tick();

        // stall count to 5, then reset while FULL
        set_op(1, 0, 5, 32'h0, 0, 0, 1, 0, 1, 1, 4'b0010, 3'd0);
        tick();
        set_op(1, 5, 20, 32'h3, 32'h4, 0, 0, 1, 1, 0, 4'b1101, 3'd0);
        repeat (4) tick();
        @(negedge clk);
        check("lit_stall_five", stall_cnt, 5);
        rst_n = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("lit_rst_no_fire", out_valid, 0);
        tick();
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        check("lit_rst_cnt", stall_cnt, 0);
        check("lit_rst_src1", src1, 0);
        check("lit_rst_rd", out_rd, 0);

        // saturation of the stall counter
        set_op(2, 0, 6, 32'h0, 0, 0, 1, 0, 1, 1, 4'b0010, 3'd0);
        tick();
        set_op(6, 0, 21, 32'h3, 32'h4, 0, 0, 0, 1, 0, 4'b0000, 3'd0);
        repeat (20) tick();
        @(negedge clk);
        check("lit_stall_sat", stall_cnt, 15);
        in_valid = 1'b0; out_ready = 1'b1;
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 Parameter: CNT_W, default 16, width of stall counter.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 flush  input  1  discard held entry (branch redirect).
REQ-005 in_valid / in_ready  input / output  1 / 1  decode-side handshake.
REQ-006 in_rs, in_rt, in_rd  input  5 each  source/destination register indices.
REQ-007 in_rs_data, in_rt_data, in_imm  input  32 each  register-file operands, sign-extended immediate.
REQ-008 in_alu_src_imm, in_uses_rt, in_reg_write, in_mem_read  input  1 each  operand-B select, rt-read flag, writeback flag, load flag.
REQ-009 in_alu_control, in_bonus_control  input  4, 3  ALU op and compare sub-op (encodings per alu_pkg).
REQ-010 fwd1_we, fwd1_rd, fwd1_data  input  1, 5, 32  EX/MEM result bus.
REQ-011 fwd2_we, fwd2_rd, fwd2_data  input  1, 5, 32  MEM/WB result bus.
REQ-012 out_valid / out_ready  output / input  1 / 1  ALU-side handshake.
REQ-013 src1, src2  output  32 each  forwarded operands driven to ALU.
REQ-014 alu_control, bonus_control  output  4, 3  held op fields.
REQ-015 out_rd, out_reg_write, out_mem_read  output  5, 1, 1  held destination info.
REQ-016 stall_cnt  output  CNT_W  saturating count of load-use stall cycles.

Function
REQ-017 Holds one entry; FSM states EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-018 Input fire = in_valid & in_ready; output fire = out_valid & out_ready; transfers occur on the clock edge.
REQ-019 hazard = FULL & out_mem_read & out_reg_write & out_rd!=0 & (in_rs==out_rd | (in_uses_rt & in_rt==out_rd)).
REQ-020 in_ready = !flush & !hazard & (EMPTY | out_ready).
REQ-021 Transitions: EMPTY+in fire->FULL; FULL+out fire+in fire->FULL (new entry); FULL+out fire, no in fire->EMPTY; FULL, no out fire->FULL (entry and outputs unchanged).
REQ-022 A hazard stalls input until the load leaves; the stage then goes EMPTY for one cycle (one bubble), and the dependent entry is accepted on the following edge.
REQ-023 flush=1: next state EMPTY, no acceptance that cycle, simultaneous out fire still counts as consumed.
REQ-024 src1 = forward(rs, rs_data); src2 = held alu_src_imm ? imm : forward(rt, rt_data); combinational from held entry and current fwd buses, zero added latency.
REQ-025 forward(r,d): fwd1_data if fwd1_we & fwd1_rd==r & r!=0; else fwd2_data if fwd2_we & fwd2_rd==r & r!=0; else d (EX/MEM has priority).
REQ-026 Register 0 never forwards; entry's rs_data/rt_data pass through unchanged when index is 0.
REQ-027 Outputs src1/src2/op fields are don't-care when EMPTY but SHALL be driven to 0.
REQ-028 stall_cnt increments each cycle in_valid & hazard, saturates at all-ones, never wraps.
REQ-029 Input-to-output latency: 1 cycle (entry visible the cycle after input fire).

Reset
REQ-030 rst_n=0 at an edge: state EMPTY, out_valid=0, all held fields 0, stall_cnt=0; in_ready=0 while rst_n=0.
REQ-031 Reset mid-transfer discards the held entry; no output fire is reported that cycle.

Structure
REQ-032 alu_pkg holds ALU_control (AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, MUL 0011, SLL 1000, SRL 1001, NOR 1100, NAND 1101) and bonus_control (SLT 000, SGT 001, SLE 010, SGE 011, SNE 100, SEQ 110) constants, shared with the ALU.
REQ-033 One sub-module, fwd_mux, implements REQ-025 and is instantiated twice.

Verification
REQ-034 ADD rs=1(5), rt=2(7), no fwd, out_ready=1 -> next cycle out_valid=1, src1=5, src2=7, alu_control=0010.
REQ-035 Held rs=3, fwd1_we=1 fwd1_rd=3 data=0xAA, fwd2_we=1 fwd2_rd=3 data=0xBB -> src1=0xAA; fwd1_rd=0 with rs=0 -> src1=rs_data.
REQ-036 Held load rd=4, incoming SUB rs=4 -> in_ready=0, one EMPTY cycle after load leaves, SUB accepted next, stall_cnt=1.
REQ-037 out_ready=0 for 3 cycles with in_valid=1 -> held entry stable, in_ready=0, no new capture.
REQ-038 FULL, flush=1 with in_valid=1 -> next cycle out_valid=0, input not accepted.
REQ-039 rst_n=0 one cycle while FULL, stall_cnt=5 -> out_valid=0, stall_cnt=0, all outputs 0.
